// File: rtl/wrr_arb_pkg.sv
// Shared constants for the weighted round-robin arbiter: defaults, FSM encodings, helpers.
package wrr_arb_pkg;

   localparam int unsigned NREQ_DFLT = 4;
   localparam int unsigned IDW_DFLT  = 2;
   localparam int unsigned QW_DFLT   = 4;
   localparam int unsigned QDEF_DFLT = 7;

   // One-hot FSM encodings
   localparam logic [2:0] ST_IDLE  = 3'b001;
   localparam logic [2:0] ST_GRANT = 3'b010;
   localparam logic [2:0] ST_GAP   = 3'b100;

   // Increment modulo n
   function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
      return ((v + 32'd1) >= n) ? 32'd0 : (v + 32'd1);
   endfunction

endpackage

// File: rtl/wrr_arb_rr_pick.sv
// Rotating-priority scan: first set request bit starting at ptr, wrapping modulo NREQ.
module wrr_arb_rr_pick
   import wrr_arb_pkg::*;
#(
   parameter int unsigned NREQ = NREQ_DFLT,
   parameter int unsigned IDW  = IDW_DFLT
)(
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic            found,
   output logic [IDW-1:0]  idx
);

   logic [IDW-1:0] k;

   // Scan offsets 0..NREQ-1 from ptr; the lowest offset with a request wins
   always_comb begin
      found = 1'b0;
      idx   = '0;
      k     = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         k = IDW'((32'(ptr) + i) % NREQ);
         if (!found && req[k]) begin
            found = 1'b1;
            idx   = k;
         end
      end
   end

endmodule

// File: rtl/wrr_arb.sv
// Weighted round-robin arbiter: one owner at a time, per-requester quota, one-cycle gap between grants.
module wrr_arb
   import wrr_arb_pkg::*;
#(
   parameter int unsigned NREQ = NREQ_DFLT,
   parameter int unsigned IDW  = IDW_DFLT,
   parameter int unsigned QW   = QW_DFLT,
   parameter int unsigned QDEF = QDEF_DFLT
)(
   input  logic            clk,
   input  logic            resetl,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] rel,
   input  logic            cfg_we,
   input  logic [IDW-1:0]  cfg_idx,
   input  logic [QW-1:0]   cfg_quota,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_id,
   output logic            busy
);

   logic [2:0]      state, state_nxt;
   logic [IDW-1:0]  own, own_nxt;
   logic [IDW-1:0]  ptr, ptr_nxt;
   logic [QW-1:0]   cntr, cntr_nxt;
   logic [QW-1:0]   qlat, qlat_nxt;
   logic [NREQ-1:0] gnt_nxt;
   logic [QW-1:0]   quota [NREQ];
   logic            pick_found;
   logic [IDW-1:0]  pick_idx;
   logic            done_c;

   wrr_arb_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
      .req   (req),
      .ptr   (ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Owner's turn ends at quota, on request drop, or on its own release strobe
   assign done_c = (cntr == qlat) | ~req[own] | rel[own];

   // Next-state and next-output decode
   always_comb begin
      state_nxt = state;
      own_nxt   = own;
      ptr_nxt   = ptr;
      cntr_nxt  = cntr;
      qlat_nxt  = qlat;
      gnt_nxt   = gnt;
      case (state)
         ST_IDLE, ST_GAP: begin
            gnt_nxt = '0;
            if (pick_found) begin
               state_nxt         = ST_GRANT;
               own_nxt           = pick_idx;
               cntr_nxt          = '0;
               qlat_nxt          = quota[pick_idx];
               gnt_nxt[pick_idx] = 1'b1;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (done_c) begin
               state_nxt = ST_GAP;
               gnt_nxt   = '0;
               ptr_nxt   = IDW'(wrap_inc(32'(own), NREQ));
            end else begin
               cntr_nxt = cntr + QW'(1);
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            gnt_nxt   = '0;
         end
      endcase
   end

   // State, owner, pointer, counter and output registers
   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         state  <= ST_IDLE;
         own    <= '0;
         ptr    <= '0;
         cntr   <= '0;
         qlat   <= QW'(QDEF);
         gnt    <= '0;
         gnt_id <= '0;
         busy   <= 1'b0;
      end else begin
         state  <= state_nxt;
         own    <= own_nxt;
         ptr    <= ptr_nxt;
         cntr   <= cntr_nxt;
         qlat   <= qlat_nxt;
         gnt    <= gnt_nxt;
         gnt_id <= own_nxt;
         busy   <= |gnt_nxt;
      end
   end

   // Quota register file; out-of-range indices are dropped
   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            quota[i] <= QW'(QDEF);
         end
      end else if (cfg_we && (32'(cfg_idx) < NREQ)) begin
         quota[cfg_idx] <= cfg_quota;
      end
   end

endmodule
